tt_response_checker: RTL and testbench

- Self-checking stimulus/response engine for small combinational blocks such as the 3-input A/B/C→Z gate circuits.
- Sequentially drives every input vector to the unit under test and reads back its Z output after a settle time.
- Compares each response against a parameterised expected truth table and reports a pass flag, a mismatch count and the first failing index.
- Hardware replacement for the hand-written exhaustive vector benches.

---
 rtl/tt_response_checker_if.sv | 39 +++
 rtl/tt_response_checker.sv | 118 +++++++++++
 tb/tb_tt_response_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tt_response_checker_if.sv
// Bundle between the response checker and the unit under test / host.
// master: the checker side; slave: the stimulus host and UUT side.
interface tt_response_checker_if #(
    parameter int unsigned N_IN = 3
);
    logic                     start;
    logic [N_IN-1:0]          vec;
    logic                     z_in;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [N_IN:0]            fail_cnt;
    logic [N_IN-1:0]          first_fail_idx;
    logic [(1<<N_IN)-1:0]     captured;

    modport master (
        input  start,
        input  z_in,
        output vec,
        output busy,
        output done,
        output pass,
        output fail_cnt,
        output first_fail_idx,
        output captured
    );

    modport slave (
        output start,
        output z_in,
        input  vec,
        input  busy,
        input  done,
        input  pass,
        input  fail_cnt,
        input  first_fail_idx,
        input  captured
    );
endinterface

// File: rtl/tt_response_checker.sv
// Exhaustive stimulus/response checker: walks every input vector of a small
// combinational UUT, samples Z after a settle time and scores it against a truth table.
module tt_response_checker #(
    parameter int unsigned          N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'hB7,
    parameter int unsigned          SETTLE   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_response_checker_if.master io_bus
);

    localparam int unsigned     CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [N_IN-1:0] IdxLast = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IdxOne  = N_IN'(1);
    localparam logic [N_IN:0]   FailOne = (N_IN + 1)'(1);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CntW-1:0]      r_cnt;
    logic [N_IN-1:0]      r_idx;
    logic [N_IN:0]        r_fail_cnt;
    logic [N_IN-1:0]      r_first_fail_idx;
    logic [(1<<N_IN)-1:0] r_captured;
    logic                 r_pass;
    logic                 w_settle_last;
    logic                 w_mismatch;
    logic                 w_last_idx;

    assign w_settle_last = (r_cnt == CntLast);
    assign w_mismatch    = (io_bus.z_in != EXPECTED[r_idx]);
    assign w_last_idx    = (r_idx == IdxLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (io_bus.start) w_state_nxt = StDrive;
            StDrive:  if (w_settle_last) w_state_nxt = StSample;
            StSample: w_state_nxt = w_last_idx ? StDone : StDrive;
            StDone:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        io_bus.busy = 1'b0;
        io_bus.done = 1'b0;
        unique case (r_state)
            StDrive, StSample: io_bus.busy = 1'b1;
            StDone:            io_bus.done = 1'b1;
            default:           ;
        endcase
    end

    // Results are only cleared on an accepted start so they survive DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt            <= '0;
            r_idx            <= '0;
            r_fail_cnt       <= '0;
            r_first_fail_idx <= '0;
            r_captured       <= '0;
            r_pass           <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_cnt            <= '0;
                        r_idx            <= '0;
                        r_fail_cnt       <= '0;
                        r_first_fail_idx <= '0;
                        r_captured       <= '0;
                        r_pass           <= 1'b0;
                    end
                end
                StDrive: begin
                    r_cnt <= w_settle_last ? '0 : r_cnt + CntOne;
                end
                StSample: begin
                    r_captured[r_idx] <= io_bus.z_in;
                    if (w_mismatch) begin
                        r_fail_cnt <= r_fail_cnt + FailOne;
                        if (r_fail_cnt == '0) r_first_fail_idx <= r_idx;
                    end
                    // Final score includes the mismatch being sampled this cycle.
                    if (w_last_idx) begin
                        r_pass <= (r_fail_cnt == '0) && !w_mismatch;
                    end else begin
                        r_idx <= r_idx + IdxOne;
                    end
                end
                StDone: begin
                    r_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.vec            = r_idx;
    assign io_bus.pass           = r_pass;
    assign io_bus.fail_cnt       = r_fail_cnt;
    assign io_bus.first_fail_idx = r_first_fail_idx;
    assign io_bus.captured       = r_captured;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker: behavioural UUT models drive z_in, and
// expected run results are queued at start and compared when done pulses.
module tb_tt_response_checker;

    localparam logic [7:0] TruthTable = 8'hB7;

    typedef struct packed {
        logic       pass;
        logic [3:0] fail_cnt;
        logic [2:0] first;
        logic [7:0] captured;
    } res_t;

    logic clk;
    logic rst_n;
    int   mode;
    int   n_checks;
    int   n_errors;
    res_t sb[$];

    tt_response_checker_if #(.N_IN(3)) bus ();

    tt_response_checker dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: correct gate, 1: tied 0, 2: tied 1, 3: AND in place of NAND
    function automatic logic uut_z(input int m, input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        case (m)
            0:       return (a & b) ^ ~(b & c);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return (a & b) ^ (b & c);
        endcase
    endfunction

    always_comb bus.z_in = uut_z(mode, bus.vec);

    function automatic res_t model(input int m);
        res_t r;
        logic z;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            z = uut_z(m, 3'(i));
            r.captured[i] = z;
            if (z != TruthTable[i]) begin
                if (r.fail_cnt == 4'd0) r.first = 3'(i);
                r.fail_cnt = r.fail_cnt + 4'd1;
            end
        end
        r.pass = (r.fail_cnt == 4'd0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_vec"},      32'(bus.vec), 32'd0);
        check({tag, "_busy"},     32'(bus.busy), 32'd0);
        check({tag, "_done"},     32'(bus.done), 32'd0);
        check({tag, "_pass"},     32'(bus.pass), 32'd0);
        check({tag, "_failcnt"},  32'(bus.fail_cnt), 32'd0);
        check({tag, "_first"},    32'(bus.first_fail_idx), 32'd0);
        check({tag, "_captured"}, 32'(bus.captured), 32'd0);
    endtask

    // Called at a negedge; counts posedges until done is seen, then scores the run.
    task automatic wait_done(input int exp_edges, input bit vec_chk, input string tag);
        int   n;
        bit   seen;
        res_t e;
        n    = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
            end else if (vec_chk) begin
                check({tag, "_vec_step"}, 32'(bus.vec), 32'(n / 3));
                check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_edge"}, 32'(n), 32'(exp_edges));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_pass"},     32'(bus.pass), 32'(e.pass));
            check({tag, "_failcnt"},  32'(bus.fail_cnt), 32'(e.fail_cnt));
            check({tag, "_captured"}, 32'(bus.captured), 32'(e.captured));
            if (e.fail_cnt != 4'd0) check({tag, "_first"}, 32'(bus.first_fail_idx), 32'(e.first));
        end
    endtask

    task automatic start_run(input int m, input string tag);
        res_t held;
        mode = m;
        sb.push_back(model(m));
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        check({tag, "_vec_start"}, 32'(bus.vec), 32'd0);
        check({tag, "_failcnt_clr"}, 32'(bus.fail_cnt), 32'd0);
        wait_done(24, 1'b1, tag);
        held = res_t'({bus.pass, bus.fail_cnt, bus.first_fail_idx, bus.captured});
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_vec_idle"}, 32'(bus.vec), 32'd0);
        check({tag, "_hold"}, 32'({bus.pass, bus.fail_cnt, bus.first_fail_idx, bus.captured}),
              32'(held));
    endtask

    initial begin
        int  k;
        bit  any_done;
        n_checks  = 0;
        n_errors  = 0;
        mode      = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        start_run(0, "good");
        start_run(1, "tied0");
        start_run(2, "tied1");
        start_run(3, "and_fault");

        // Async reset at edge 10 of a run leaves no done pulse behind.
        mode      = 1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done || bus.busy) any_done = 1'b1;
        end
        check("abort_no_done", 32'(any_done), 32'd0);
        start_run(0, "post_abort");

        // start pulsed mid-run and held across DONE: one done, then one more run.
        mode = 0;
        sb.push_back(model(0));
        sb.push_back(model(0));
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (k = 1; k <= 22; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("repulse_done_low", 32'(bus.done), 32'd0);
            bus.start = (k == 4) || (k >= 22);
        end
        wait_done(2, 1'b0, "repulse_first");
        wait_done(26, 1'b0, "repulse_second");
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("repulse_end_done", 32'(bus.done), 32'd0);
        check("repulse_end_busy", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
